shift_sequencer: RTL and testbench

- Multi-cycle controller that performs a variable-amount 32-bit shift or rotate.
- It does this by repeatedly applying a fixed shift-by-2 step (shift-by-1 for an odd remainder) to an internal accumulator.
- It sits beside the ALU and serves shift-class instructions (sll/srl/sra/rol), using a start/done handshake so the CPU control unit can stall until the result is ready.
- It replaces a full barrel shifter with a 2-bit step datapath plus a counter.

---
 rtl/shift_sequencer.sv | 78 +++++++
 tb/tb_shift_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate built from a 2-bit step datapath and a down-counter.
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d, result_q, result_d, step_acc;
  logic [SHAMT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [1:0]         op_q, op_d;
  logic               two;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= 2'b00;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end
  // One step moves by 2 unless only a single bit of shift remains.
  always_comb begin
    two      = cnt_q >= SHAMT_W'(2);
    cnt_nxt  = two ? cnt_q - SHAMT_W'(2) : '0;
    step_acc = op_q == 2'b00 ? (two ? {acc_q[WIDTH-3:0], 2'b00} : {acc_q[WIDTH-2:0], 1'b0}) :
               op_q == 2'b01 ? (two ? {2'b00, acc_q[WIDTH-1:2]} : {1'b0, acc_q[WIDTH-1:1]}) :
               op_q == 2'b10 ? (two ? {{2{acc_q[WIDTH-1]}}, acc_q[WIDTH-1:2]} : {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}) :
                               (two ? {acc_q[WIDTH-3:0], acc_q[WIDTH-1:WIDTH-2]} : {acc_q[WIDTH-2:0], acc_q[WIDTH-1]});
  end
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d    = data_in;
        cnt_d    = shamt;
        op_d     = op;
        state_d  = shamt == '0 ? DONE : SHIFT;
        result_d = shamt == '0 ? data_in : result_q;
      end
      SHIFT: begin
        acc_d = step_acc;
        cnt_d = cnt_nxt;
        if (cnt_nxt == '0) begin
          state_d  = DONE;
          result_d = step_acc;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ready  = state_q == IDLE;
    busy   = state_q == SHIFT || state_q == DONE;
    done   = state_q == DONE;
    result = result_q;
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed table plus randomized ops checked against an arithmetic shift model.
module tb_shift_sequencer;
  logic        clk = 0, rst_n = 0, start = 0;
  logic [1:0]  op = 0;
  logic [31:0] data_in = 0;
  logic [4:0]  shamt = 0;
  logic        ready, busy, done;
  logic [31:0] result;
  int checks = 0, errors = 0;

  shift_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .data_in(data_in),
    .shamt(shamt), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    int          intrude;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int s);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
      default: return s == 0 ? d : (d << s) | (d >> (32 - s));
    endcase
  endfunction

  // Issues one operation on the next idle cycle, optionally pulsing junk starts while busy.
  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                       input int intrude, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({nm, " ready_idle"}, {31'b0, ready}, 1);
    chk({nm, " done_idle"}, {31'b0, done}, 0);
    start = 1; op = o; data_in = d; shamt = s;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!done && lat < 40) begin
      if (busy !== 1'b1 || ready !== 1'b0) begin
        checks++; errors++;
        $display("FAIL %s busy_phase: busy=%b ready=%b expected busy=1 ready=0", nm, busy, ready);
      end
      start = lat <= intrude; op = 2'b01; data_in = $urandom; shamt = 5'd1;
      @(negedge clk);
      lat++;
    end
    start = 0;
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " result"}, result, exp);
    chk({nm, " busy_done"}, {31'b0, busy}, 1);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{2'b00, 32'h00000001, 5'd31, 0, 32'h80000000, 17});
    vecs.push_back('{2'b10, 32'h80000000, 5'd4,  0, 32'hF8000000, 3});
    vecs.push_back('{2'b01, 32'h80000000, 5'd4,  0, 32'h08000000, 3});
    vecs.push_back('{2'b11, 32'h80000001, 5'd3,  0, 32'h0000000C, 3});
    vecs.push_back('{2'b00, 32'h12345678, 5'd0,  0, 32'h12345678, 1});
    vecs.push_back('{2'b00, 32'hFFFFFFFF, 5'd8,  2, 32'hFFFFFF00, 5});
    vecs.push_back('{2'b00, 32'h00000001, 5'd1,  0, 32'h00000002, 2});
    vecs.push_back('{2'b10, 32'h7FFFFFFF, 5'd31, 0, 32'h00000000, 17});
    vecs.push_back('{2'b11, 32'hA5A5A5A5, 5'd2,  0, 32'h96969696, 2});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", {31'b0, ready}, 1);
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset result", result, 0);
    rst_n = 1;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].shamt,
            vecs[i].intrude, vecs[i].exp, vecs[i].lat);

    // Reset in the 4th SHIFT cycle must abort with no done pulse.
    @(negedge clk);
    start = 1; op = 2'b01; data_in = 32'hFFFFFFFF; shamt = 5'd20;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    chk("abort in_shift", {31'b0, busy}, 1);
    rst_n = 0;
    @(negedge clk);
    chk("abort ready", {31'b0, ready}, 1);
    chk("abort busy", {31'b0, busy}, 0);
    chk("abort done", {31'b0, done}, 0);
    chk("abort result", result, 0);
    rst_n = 1;
    repeat (12) begin
      @(negedge clk);
      chk("abort no_done", {31'b0, done}, 0);
    end
    do_op("post_abort", 2'b01, 32'hF0000000, 5'd5, 0, 32'h07800000, 4);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] d;
      logic [4:0]  s;
      o = 2'($urandom);
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      do_op($sformatf("rnd%0d", i), o, d, s, int'($urandom_range(0, 1)), model(o, d, int'(s)), 1 + (int'(s) + 1) / 2);
    end

    @(negedge clk);
    chk("final ready", {31'b0, ready}, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
